vga_spi_frame_tx: RTL and testbench

//  SPI mode-0 master that streams one full frame to the vga_spi receiver. On start it sends
//  the align byte 0x80, then RES_X*RES_Y pixel bytes {2'b00,RR,GG,BB}, then the swap byte 0x81.

---
 rtl/vga_spi_frame_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_vga_spi_frame_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_spi_frame_tx.sv
// SPI mode-0 master that streams one frame to the vga_spi receiver:
// align byte 0x80, RES_X*RES_Y pixel bytes {2'b00,RR,GG,BB}, then swap byte 0x81.
module vga_spi_frame_tx #(
    parameter  int RES_X   = 320,
    parameter  int RES_Y   = 240,
    parameter  int CLK_DIV = 2,
    parameter  int CS_GAP  = 2,
    localparam int NPIX    = RES_X * RES_Y,
    localparam int CW      = $clog2(NPIX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [5:0]    pix_data,
    input  logic          pix_valid,
    output logic          pix_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pix_count,
    output logic          sclk,
    output logic          cs_n,
    output logic          mosi
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETUP, S_BLO, S_BHI, S_HOLD, S_GAP, S_FIN
    } state_t;

    typedef enum logic [1:0] {
        PH_ALIGN, PH_PIX, PH_SWAP
    } phase_t;

    localparam int            TMAX     = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int            TW       = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(CS_GAP - 1);
    localparam logic [CW-1:0] NPIX_C   = CW'(NPIX);
    localparam logic [7:0]    ALIGN_B  = 8'h80;
    localparam logic [7:0]    SWAP_B   = 8'h81;

    state_t        r_state, w_state_nxt;
    phase_t        r_phase, w_phase_nxt;
    logic [7:0]    r_shreg, w_shreg_nxt;
    logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
    logic [TW-1:0] r_tmr, w_tmr_nxt;
    logic [CW-1:0] r_pix_count, w_pix_count_nxt;
    logic          r_sclk, w_sclk_nxt;
    logic          r_cs_n, w_cs_n_nxt;
    logic          r_mosi, w_mosi_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;

    logic          w_div_done;
    logic          w_gap_done;
    logic          w_load_go;
    logic [7:0]    w_load_byte;
    logic [CW-1:0] w_pix_inc;

    assign w_div_done = (r_tmr == DIV_LAST);
    assign w_gap_done = (r_tmr == GAP_LAST);
    assign w_pix_inc  = (r_pix_count == NPIX_C) ? r_pix_count : r_pix_count + CW'(1);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_shreg_nxt     = r_shreg;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_tmr_nxt       = r_tmr + TW'(1);
        w_pix_count_nxt = r_pix_count;
        w_sclk_nxt      = r_sclk;
        w_cs_n_nxt      = r_cs_n;
        w_mosi_nxt      = r_mosi;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_load_go       = 1'b0;
        w_load_byte     = ALIGN_B;

        unique case (r_state)
            S_IDLE: begin
                w_tmr_nxt = '0;
                if (start) begin
                    w_phase_nxt     = PH_ALIGN;
                    w_pix_count_nxt = '0;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = S_LOAD;
                end
            end

            S_LOAD: begin
                w_tmr_nxt = '0;
                case (r_phase)
                    PH_ALIGN: begin
                        w_load_go   = 1'b1;
                        w_load_byte = ALIGN_B;
                    end
                    PH_SWAP: begin
                        w_load_go   = 1'b1;
                        w_load_byte = SWAP_B;
                    end
                    PH_PIX: begin
                        w_load_go   = pix_valid;
                        w_load_byte = {2'b00, pix_data};
                    end
                    default: w_load_go = 1'b0;
                endcase
                // A stalled pixel stream leaves cs_n high until data is available.
                if (w_load_go) begin
                    w_shreg_nxt   = w_load_byte;
                    w_mosi_nxt    = w_load_byte[7];
                    w_bit_cnt_nxt = '0;
                    w_cs_n_nxt    = 1'b0;
                    w_state_nxt   = S_SETUP;
                end
            end

            S_SETUP: begin
                if (w_div_done) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_BLO;
                end
            end

            S_BLO: begin
                if (w_div_done) begin
                    w_tmr_nxt   = '0;
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = S_BHI;
                end
            end

            S_BHI: begin
                // mosi moves only together with the falling sclk edge (mode 0).
                if (w_div_done) begin
                    w_tmr_nxt     = '0;
                    w_sclk_nxt    = 1'b0;
                    w_shreg_nxt   = {r_shreg[6:0], 1'b0};
                    w_mosi_nxt    = (r_bit_cnt == 3'd7) ? 1'b0 : r_shreg[6];
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    w_state_nxt   = (r_bit_cnt == 3'd7) ? S_HOLD : S_BLO;
                end
            end

            S_HOLD: begin
                if (w_div_done) begin
                    w_tmr_nxt   = '0;
                    w_cs_n_nxt  = 1'b1;
                    w_mosi_nxt  = 1'b0;
                    w_state_nxt = S_GAP;
                end
            end

            S_GAP: begin
                if (w_gap_done) begin
                    w_tmr_nxt = '0;
                    case (r_phase)
                        PH_ALIGN: begin
                            w_phase_nxt = PH_PIX;
                            w_state_nxt = S_LOAD;
                        end
                        PH_PIX: begin
                            w_pix_count_nxt = w_pix_inc;
                            if (w_pix_inc == NPIX_C) w_phase_nxt = PH_SWAP;
                            w_state_nxt = S_LOAD;
                        end
                        PH_SWAP: begin
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = S_FIN;
                        end
                        default: w_state_nxt = S_LOAD;
                    endcase
                end
            end

            S_FIN: begin
                w_tmr_nxt   = '0;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_tmr_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_phase     <= PH_ALIGN;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_tmr       <= '0;
            r_pix_count <= '0;
            r_sclk      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_shreg     <= w_shreg_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_tmr       <= w_tmr_nxt;
            r_pix_count <= w_pix_count_nxt;
            r_sclk      <= w_sclk_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_mosi      <= w_mosi_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign pix_ready = (r_state == S_LOAD) && (r_phase == PH_PIX);
    assign busy      = r_busy;
    assign done      = r_done;
    assign pix_count = r_pix_count;
    assign sclk      = r_sclk;
    assign cs_n      = r_cs_n;
    assign mosi      = r_mosi;

endmodule

// File: tb/tb_vga_spi_frame_tx.sv
// Directed bench for vga_spi_frame_tx at 4x2 resolution: an SPI monitor decodes the
// bytes on the wire and hand-computed frames, cycle counts and abort behaviour are checked.
module tb_vga_spi_frame_tx;

    localparam int RES_X   = 4;
    localparam int RES_Y   = 2;
    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;
    localparam int CW      = $clog2(RES_X * RES_Y + 1);
    // 10 bytes of 1 + 18*CLK_DIV + CS_GAP cycles, plus the start edge
    localparam int FRAME_CYC = 10 * (1 + 36 + 2) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [5:0]    pix_data;
    logic          pix_valid;
    logic          pix_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] pix_count;
    logic          sclk;
    logic          cs_n;
    logic          mosi;

    vga_spi_frame_tx #(
        .RES_X  (RES_X),
        .RES_Y  (RES_Y),
        .CLK_DIV(CLK_DIV),
        .CS_GAP (CS_GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pix_data (pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .busy     (busy),
        .done     (done),
        .pix_count(pix_count),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int stall_bad = 0;
    logic [5:0] pix_tab [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SPI monitor: bits on sclk rise while cs_n low, one byte per cs_n assertion.
    logic       prev_sclk = 1'b0;
    logic       prev_cs_n = 1'b1;
    logic       prev_mosi = 1'b0;
    logic [7:0] mon_sh    = 8'h00;
    int         mon_bits  = 0;
    int         cs_fall   = 0;
    int         mode_err  = 0;
    int         stray     = 0;
    int         done_cnt  = 0;
    logic [7:0] byte_q [$];
    int         bits_q [$];

    always @(negedge clk) begin
        if (rst) begin
            mon_bits <= 0;
        end else begin
            if (prev_cs_n && !cs_n) cs_fall <= cs_fall + 1;
            if (sclk && (mosi !== prev_mosi)) mode_err <= mode_err + 1;
            if (!prev_sclk && sclk) begin
                if (cs_n) begin
                    stray <= stray + 1;
                end else begin
                    mon_sh   <= {mon_sh[6:0], mosi};
                    mon_bits <= mon_bits + 1;
                end
            end
            if (!prev_cs_n && cs_n) begin
                byte_q.push_back(mon_sh);
                bits_q.push_back(mon_bits);
                mon_bits <= 0;
            end
            if (done) done_cnt <= done_cnt + 1;
        end
        prev_sclk <= sclk;
        prev_cs_n <= cs_n;
        prev_mosi <= mosi;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame. stall_at: pixel index to hold back for stall_len cycles once
    // pix_ready rises for it; poke: extra start at cycle 100; abort_pix: return during
    // bit 4 of that pixel instead of waiting for done.
    task automatic run_frame(input int stall_at, input int stall_len, input bit poke,
                             input int abort_pix, output int cycles, output bit got_done);
        int   n_acc;
        int   stall_left;
        int   rises;
        bit   stalled;
        bit   hs;
        logic pv_sclk;
        n_acc      = 0;
        stall_left = 0;
        rises      = 0;
        stalled    = 1'b0;
        cycles     = 0;
        got_done   = 1'b0;
        pv_sclk    = sclk;
        start      = 1'b1;
        pix_valid  = 1'b1;
        pix_data   = pix_tab[0];
        while (cycles < 3000) begin
            hs = pix_valid && pix_ready;
            @(posedge clk);
            cycles++;
            #1;
            start = 1'b0;
            if (hs) n_acc++;
            if (cycles == 1) check("busy_after_start", busy, 1);
            if (poke && cycles == 100) start = 1'b1;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (abort_pix >= 0 && n_acc == abort_pix + 1) begin
                if (sclk && !pv_sclk) rises++;
                if (rises == 5) break;
            end
            pv_sclk = sclk;
            if (stall_at >= 0 && n_acc == stall_at && pix_ready && !stalled) begin
                stalled    = 1'b1;
                stall_left = stall_len;
                check("stall_pix_count", pix_count, stall_at);
            end
            if (stall_left > 0) begin
                if (cs_n !== 1'b1 || sclk !== 1'b0 || pix_ready !== 1'b1) stall_bad++;
                stall_left--;
                pix_valid = 1'b0;
            end else begin
                pix_valid = 1'b1;
            end
            pix_data = pix_tab[n_acc % 8];
        end
        if (abort_pix < 0 && !got_done) check("done_timeout", 0, 1);
    endtask

    task automatic check_frame(input int mark, input int cs_mark);
        int bad;
        bad = 0;
        check("frame_bytes", byte_q.size() - mark, 10);
        check("cs_pulses", cs_fall - cs_mark, 10);
        if (byte_q.size() >= mark + 10) begin
            check("align_byte", byte_q[mark], 8'h80);
            for (int i = 0; i < 8; i++)
                check($sformatf("pix_byte%0d", i), byte_q[mark + 1 + i], {2'b00, pix_tab[i]});
            check("swap_byte", byte_q[mark + 9], 8'h81);
            for (int i = 0; i < 10; i++)
                if (bits_q[mark + i] != 8) bad++;
            check("bits_per_byte", bad, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  got;
        int  mark;
        int  cs_mark;
        int  done_mark;

        rst       = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 6'h00;
        idle(3);
        check("rst_sclk", sclk, 0);
        check("rst_cs_n", cs_n, 1);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_pix_count", pix_count, 0);
        rst = 1'b0;
        pix_valid = 1'b1;
        idle(3);
        check("idle_valid_ignored", pix_ready, 0);

        // Frame of constant 0x1B pixels with no stalls.
        for (int i = 0; i < 8; i++) pix_tab[i] = 6'h1B;
        mark    = byte_q.size();
        cs_mark = cs_fall;
        run_frame(-1, 0, 1'b0, -1, cyc, got);
        check("f1_cycles", cyc, FRAME_CYC);
        check("f1_busy_at_done", busy, 0);
        check("f1_pix_count", pix_count, 8);
        idle(1);
        check("f1_done_pulse_len", done, 0);
        check_frame(mark, cs_mark);
        idle(5);
        check("f1_count_holds", pix_count, 8);
        check("f1_idle_ready", pix_ready, 0);

        // Distinct pixels, 20-cycle stall before pixel 3.
        pix_tab = '{6'h3F, 6'h00, 6'h2A, 6'h15, 6'h01, 6'h20, 6'h3E, 6'h0C};
        mark    = byte_q.size();
        cs_mark = cs_fall;
        run_frame(3, 20, 1'b0, -1, cyc, got);
        check("f2_cycles", cyc, FRAME_CYC + 20);
        check("f2_pix_count", pix_count, 8);
        check("stall_quiet", stall_bad, 0);
        check_frame(mark, cs_mark);
        idle(3);

        // Start while busy and during FIN must both be ignored.
        mark      = byte_q.size();
        cs_mark   = cs_fall;
        done_mark = done_cnt;
        run_frame(-1, 0, 1'b1, -1, cyc, got);
        check("f3_cycles", cyc, FRAME_CYC);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle(3);
        check("fin_start_busy", busy, 0);
        idle(60);
        check("f3_done_pulses", done_cnt - done_mark, 1);
        check("fin_start_no_bytes", cs_fall - cs_mark, 10);
        check_frame(mark, cs_mark);

        // Reset during bit 4 of pixel 2, then a clean frame.
        run_frame(-1, 0, 1'b0, 2, cyc, got);
        check("abort_mid_byte_busy", busy, 1);
        check("abort_mid_byte_cs", cs_n, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_sclk", sclk, 0);
        check("abort_cs_n", cs_n, 1);
        check("abort_busy", busy, 0);
        check("abort_mosi", mosi, 0);
        check("abort_pix_count", pix_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        mark    = byte_q.size();
        cs_mark = cs_fall;
        run_frame(-1, 0, 1'b0, -1, cyc, got);
        check("f4_cycles", cyc, FRAME_CYC);
        check("f4_pix_count", pix_count, 8);
        check_frame(mark, cs_mark);
        idle(3);

        check("mode0_mosi_stable", mode_err, 0);
        check("sclk_outside_cs", stray, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
